// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencer: holds DEPTH operands and steps one shared external
// magnitude comparator over adjacent pairs, swapping on "greater", with early exit.
module bubble_sort_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int IDX_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             start,
    output logic             start_err,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] swap_cnt,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             cmp_gt,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_SWAP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W:0]   DEPTH_W   = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W:0]   TOP_W     = (IDX_W + 1)'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);

    state_t           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W:0]   load_cnt_q;
    logic [IDX_W-1:0] j_q;
    logic [IDX_W-1:0] pass_q;
    logic             swapped_q;
    logic             busy_q;
    logic             done_q;
    logic             start_err_q;
    logic [CNT_W-1:0] swap_cnt_q;

    logic [IDX_W-1:0] j_p1;
    logic             more_pairs;
    logic             swapped_d;
    logic             load_full;
    logic             load_fire;
    state_t           adv_state_d;
    logic [IDX_W-1:0] adv_j_d;
    logic [IDX_W-1:0] adv_pass_d;
    logic             adv_swapped_d;

    // Step taken after every CMP (no swap) or SWAP: next pair, next pass, or finish.
    always_comb begin
        j_p1          = j_q + IDX_W'(1);
        more_pairs    = ({1'b0, j_q} + (IDX_W + 1)'(1)) < (TOP_W - {1'b0, pass_q});
        swapped_d     = swapped_q | (state_q == S_SWAP);
        adv_state_d   = S_CMP;
        adv_j_d       = j_q;
        adv_pass_d    = pass_q;
        adv_swapped_d = swapped_d;
        if (more_pairs) begin
            adv_j_d = j_p1;
        end else if (!swapped_d || (pass_q == LAST_PASS)) begin
            adv_state_d = S_DONE;
        end else begin
            adv_pass_d    = pass_q + IDX_W'(1);
            adv_j_d       = '0;
            adv_swapped_d = 1'b0;
        end
    end

    assign load_full = (load_cnt_q == DEPTH_W);
    assign in_ready  = (state_q == S_IDLE) && !load_full;
    assign load_fire = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            load_cnt_q  <= '0;
            j_q         <= '0;
            pass_q      <= '0;
            swapped_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            swap_cnt_q  <= '0;
        end else begin
            start_err_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_fire) begin
                        mem_q[load_cnt_q[IDX_W-1:0]] <= in_data;
                        load_cnt_q <= load_cnt_q + (IDX_W + 1)'(1);
                    end
                    if (start) begin
                        if (load_full) begin
                            state_q    <= S_CMP;
                            busy_q     <= 1'b1;
                            j_q        <= '0;
                            pass_q     <= '0;
                            swapped_q  <= 1'b0;
                            swap_cnt_q <= '0;
                        end else begin
                            start_err_q <= 1'b1;
                        end
                    end
                end
                S_CMP: begin
                    if (cmp_gt) begin
                        state_q <= S_SWAP;
                    end else begin
                        state_q   <= adv_state_d;
                        j_q       <= adv_j_d;
                        pass_q    <= adv_pass_d;
                        swapped_q <= adv_swapped_d;
                        if (adv_state_d == S_DONE) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SWAP: begin
                    mem_q[j_q]  <= mem_q[j_p1];
                    mem_q[j_p1] <= mem_q[j_q];
                    if (swap_cnt_q != '1) swap_cnt_q <= swap_cnt_q + CNT_W'(1);
                    state_q   <= adv_state_d;
                    j_q       <= adv_j_d;
                    pass_q    <= adv_pass_d;
                    swapped_q <= adv_swapped_d;
                    if (adv_state_d == S_DONE) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    load_cnt_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign start_err   = start_err_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign swap_cnt    = swap_cnt_q;
    assign rd_data     = mem_q[rd_idx];
    assign cmp_a       = mem_q[j_q];
    assign cmp_b       = mem_q[j_p1];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Self-checking bench for bubble_sort_ctrl: fixed vector table, hand sequences
// for start error and mid-sort reset, and randomized sorts against a reference model.
module tb_bubble_sort_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             start = 1'b0;
    logic             start_err;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] swap_cnt;
    logic [IDX_W-1:0] rd_idx = '0;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_gt;
    logic [1:0]       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0][7:0] v;
        logic [3:0][7:0] s;
        int              swaps;
        int              cmps;
        int              busy;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    // External comparator
    assign cmp_gt = (cmp_a > cmp_b);

    bubble_sort_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .start(start), .start_err(start_err), .busy(busy),
        .done(done), .swap_cnt(swap_cnt), .rd_idx(rd_idx), .rd_data(rd_data),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt), .dbg_state_o(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0][7:0] pack4(input int a, input int b, input int c, input int d);
        logic [3:0][7:0] r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
        return r;
    endfunction

    // Reference: stable sorted order, swaps = inversion count, passes from the
    // largest count of bigger elements sitting ahead of any element.
    function automatic vec_t model(input logic [3:0][7:0] v);
        vec_t r;
        int a[4];
        int inv, lmax, li, pos, passes;
        for (int i = 0; i < 4; i++) a[i] = int'(v[i]);
        inv = 0; lmax = 0;
        for (int i = 0; i < 4; i++) begin
            li = 0;
            for (int k = 0; k < i; k++) if (a[k] > a[i]) li++;
            inv += li;
            if (li > lmax) lmax = li;
        end
        for (int i = 0; i < 4; i++) begin
            pos = 0;
            for (int k = 0; k < 4; k++) if (a[k] < a[i] || (a[k] == a[i] && k < i)) pos++;
            r.s[pos] = 8'(a[i]);
        end
        passes = (lmax + 1 < DEPTH - 1) ? lmax + 1 : DEPTH - 1;
        r.cmps = 0;
        for (int p = 0; p < passes; p++) r.cmps += DEPTH - 1 - p;
        r.v = v; r.swaps = inv; r.busy = r.cmps + inv;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_val(input string tag, input logic [7:0] v);
        check($sformatf("%s.in_ready_load", tag), in_ready, 1);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic read_all(input string tag, input logic [3:0][7:0] exp);
        for (int i = 0; i < 4; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            check($sformatf("%s.rd%0d", tag, i), rd_data, exp[i]);
        end
    endtask

    task automatic sort_and_check(input string tag, input vec_t t, input bit noise);
        int busy_n, cmp_n, guard;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s.first_cmp_a", tag), cmp_a, t.v[0]);
        check($sformatf("%s.first_cmp_b", tag), cmp_b, t.v[1]);
        busy_n = 0; cmp_n = 0; guard = 0;
        while (busy === 1'b1 && guard < 100) begin
            busy_n++;
            if (dbg_state == 2'd1) cmp_n++;
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom_range(0, 255));
                start    = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check($sformatf("%s.busy_cycles", tag), busy_n, t.busy);
        check($sformatf("%s.cmp_cycles", tag), cmp_n, t.cmps);
        check($sformatf("%s.done", tag), done, 1);
        check($sformatf("%s.swap_cnt", tag), swap_cnt, t.swaps);
        @(negedge clk);
        check($sformatf("%s.done_clear", tag), done, 0);
        check($sformatf("%s.in_ready_after", tag), in_ready, 1);
        read_all(tag, t.s);
    endtask

    task automatic run_sort(input string tag, input vec_t t, input bit noise);
        for (int i = 0; i < 4; i++) load_val(tag, t.v[i]);
        check($sformatf("%s.in_ready_full", tag), in_ready, 0);
        sort_and_check(tag, t, noise);
    endtask

    task automatic fill(input int n, input logic [3:0][7:0] v, input logic [3:0][7:0] s,
                        input int swaps, input int cmps, input int busy_c);
        tbl[n].v = v; tbl[n].s = s; tbl[n].swaps = swaps; tbl[n].cmps = cmps; tbl[n].busy = busy_c;
    endtask

    initial begin
        vec_t rv;
        logic [3:0][7:0] rnd;
        int guard;

        fill(0, pack4(4, 3, 2, 1),     pack4(1, 2, 3, 4),     6, 6, 12);
        fill(1, pack4(1, 2, 3, 4),     pack4(1, 2, 3, 4),     0, 3, 3);
        fill(2, pack4(5, 5, 2, 5),     pack4(2, 5, 5, 5),     2, 6, 8);
        fill(3, pack4(255, 0, 128, 0), pack4(0, 0, 128, 255), 4, 6, 10);
        fill(4, pack4(9, 7, 5, 3),     pack4(3, 5, 7, 9),     6, 6, 12);
        fill(5, pack4(7, 7, 7, 7),     pack4(7, 7, 7, 7),     0, 3, 3);
        fill(6, pack4(2, 1, 3, 4),     pack4(1, 2, 3, 4),     1, 5, 6);

        do_reset();
        check("reset.in_ready", in_ready, 1);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.start_err", start_err, 0);
        check("reset.swap_cnt", swap_cnt, 0);
        check("reset.state", dbg_state, 0);
        read_all("reset", pack4(0, 0, 0, 0));

        for (int n = 0; n < 7; n++) run_sort($sformatf("vec%0d", n), tbl[n], 1'b0);

        // Start with too few entries, with a load accepted in the same cycle
        do_reset();
        load_val("err", 8'd8);
        load_val("err", 8'd1);
        start = 1'b1; in_valid = 1'b1; in_data = 8'd6;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        check("err.start_err", start_err, 1);
        check("err.busy", busy, 0);
        check("err.in_ready", in_ready, 1);
        check("err.state", dbg_state, 0);
        @(negedge clk);
        check("err.start_err_clear", start_err, 0);
        load_val("err", 8'd3);
        check("err.in_ready_full", in_ready, 0);
        sort_and_check("err", model(pack4(8, 1, 6, 3)), 1'b0);

        // Reset during the first swap
        do_reset();
        for (int i = 0; i < 4; i++) load_val("rst", tbl[4].v[i]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (dbg_state != 2'd2 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rst.reached_swap", dbg_state, 2);
        rst_n = 1'b0;
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.swap_cnt", swap_cnt, 0);
        check("rst.state", dbg_state, 0);
        read_all("rst", pack4(0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", in_ready, 1);
        run_sort("rst_reload", tbl[4], 1'b0);

        // Randomized sorts, back to back, with ignored traffic while busy
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 4; i++)
                rnd[i] = (it % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            rv = model(rnd);
            run_sort($sformatf("rand%0d", it), rv, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
